// File: rtl/key_event_decoder.sv
// Classifies debounced key presses into click, double-click and long-press
// pulses, plus a registered held level.
module key_event_decoder #(
  parameter int CNT_W    = 22,
  parameter int LONG_CYC = 4000000,
  parameter int GAP_CYC  = 1200000
) (
  input  logic clk4m,
  input  logic rst,
  input  logic key_deb,
  output logic held_o,
  output logic click_o,
  output logic dbl_o,
  output logic long_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_GAP,
    S_PRESS2,
    S_LONG
  } state_t;

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_key_q;
  logic             r_armed;
  logic             r_click;
  logic             r_dbl;
  logic             r_long;

  logic w_rise;
  logic w_fall;
  logic w_long_tc;
  logic w_gap_tc;
  logic w_click_nxt;
  logic w_dbl_nxt;
  logic w_long_nxt;

  // The first edge after reset only captures the level, so no edge is seen
  assign w_rise    = r_armed &  key_deb & ~r_key_q;
  assign w_fall    = r_armed & ~key_deb &  r_key_q;
  assign w_long_tc = (r_cnt == LONG_TC);
  assign w_gap_tc  = (r_cnt == GAP_TC);
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

  always_ff @(posedge clk4m) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_key_q <= 1'b0;
      r_armed <= 1'b0;
      r_click <= 1'b0;
      r_dbl   <= 1'b0;
      r_long  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_key_q <= key_deb;
      r_armed <= 1'b1;
      r_click <= w_click_nxt;
      r_dbl   <= w_dbl_nxt;
      r_long  <= w_long_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_armed) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            w_state_nxt = S_PRESS1;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        S_PRESS1: begin
          if (w_fall) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = CNT_ONE;
          end else if (w_long_tc) begin
            w_state_nxt = S_LONG;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        S_GAP: begin
          if (w_rise) begin
            w_state_nxt = S_PRESS2;
            w_cnt_nxt   = CNT_ONE;
          end else if (w_gap_tc) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        S_PRESS2: begin
          if (w_fall) begin
            w_state_nxt = S_IDLE;
          end else if (w_long_tc) begin
            w_state_nxt = S_LONG;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        S_LONG: begin
          if (w_fall) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Edges take priority over terminal counts when both land together
  always_comb begin
    w_click_nxt = 1'b0;
    w_dbl_nxt   = 1'b0;
    w_long_nxt  = 1'b0;
    if (r_armed) begin
      unique case (1'b1)
        (r_state == S_GAP): begin
          w_click_nxt = ~w_rise & w_gap_tc;
        end
        (r_state == S_PRESS1): begin
          w_long_nxt  = ~w_fall & w_long_tc;
        end
        (r_state == S_PRESS2): begin
          w_dbl_nxt   = w_fall;
          w_long_nxt  = ~w_fall & w_long_tc;
        end
        default: begin
          w_click_nxt = 1'b0;
        end
      endcase
    end
  end

  assign held_o  = r_key_q;
  assign click_o = r_click;
  assign dbl_o   = r_dbl;
  assign long_o  = r_long;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: expected pulses are queued
// per clock edge and compared every cycle against the outputs.
module tb_key_event_decoder;
  localparam int LC = 20;
  localparam int GC = 8;
  localparam int W  = 8;

  localparam logic [2:0] EV_CLICK = 3'b100;
  localparam logic [2:0] EV_DBL   = 3'b010;
  localparam logic [2:0] EV_LONG  = 3'b001;

  logic clk4m   = 1'b0;
  logic rst     = 1'b1;
  logic key_deb = 1'b0;
  logic held_o;
  logic click_o;
  logic dbl_o;
  logic long_o;

  int   cyc       = 0;
  int   checks    = 0;
  int   errors    = 0;
  int   last_edge = 0;
  bit   mon_en    = 1'b0;
  logic prev_key  = 1'b0;

  typedef struct {
    int         cyc;
    logic [2:0] ev;
  } exp_t;
  exp_t sbq[$];

  key_event_decoder #(
    .CNT_W   (W),
    .LONG_CYC(LC),
    .GAP_CYC (GC)
  ) dut (
    .clk4m  (clk4m),
    .rst    (rst),
    .key_deb(key_deb),
    .held_o (held_o),
    .click_o(click_o),
    .dbl_o  (dbl_o),
    .long_o (long_o)
  );

  always #5 clk4m = ~clk4m;

  always @(posedge clk4m) begin
    cyc      <= cyc + 1;
    prev_key <= rst ? 1'b0 : key_deb;
  end

  always @(negedge clk4m) begin
    logic [2:0] obs;
    logic [2:0] want;
    if (mon_en) begin
      obs  = {click_o, dbl_o, long_o};
      want = 3'b000;
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        want = sbq[0].ev;
        void'(sbq.pop_front());
      end
      checks++;
      assert (obs === want) else begin
        errors++;
        $error("FAIL events cyc=%0d got=%b exp=%b", cyc, obs, want);
      end
      checks++;
      assert (held_o === prev_key) else begin
        errors++;
        $error("FAIL held cyc=%0d got=%b exp=%b", cyc, held_o, prev_key);
      end
    end
  end

  task automatic step(input logic k, input logic r, input int n);
    repeat (n) begin
      @(negedge clk4m);
      key_deb   = k;
      rst       = r;
      last_edge = cyc + 1;
    end
  endtask

  task automatic push(input logic [2:0] ev);
    exp_t e;
    e.cyc = last_edge;
    e.ev  = ev;
    sbq.push_back(e);
  endtask

  initial begin
    @(posedge clk4m);
    mon_en = 1'b1;
    step(0, 1, 2);
    step(0, 0, 1);
    // single click
    step(1, 0, 5);
    step(0, 0, GC);
    push(EV_CLICK);
    step(0, 0, 4);
    // double click
    step(1, 0, 3);
    step(0, 0, 4);
    step(1, 0, 3);
    step(0, 0, 1);
    push(EV_DBL);
    step(0, 0, 12);
    // long press
    step(1, 0, LC);
    push(EV_LONG);
    step(1, 0, 5);
    step(0, 0, 10);
    // fall on the long terminal edge
    step(1, 0, LC - 1);
    step(0, 0, GC);
    push(EV_CLICK);
    step(0, 0, 3);
    // rise on the gap terminal edge
    step(1, 0, 3);
    step(0, 0, GC - 1);
    step(1, 0, 3);
    step(0, 0, 1);
    push(EV_DBL);
    step(0, 0, 10);
    // gap fully elapsed: two clicks
    step(1, 0, 3);
    step(0, 0, GC);
    push(EV_CLICK);
    step(1, 0, 3);
    step(0, 0, GC);
    push(EV_CLICK);
    step(0, 0, 4);
    // held through reset
    step(1, 1, 2);
    step(1, 0, 30);
    step(0, 0, 3);
    step(1, 0, 3);
    step(0, 0, GC);
    push(EV_CLICK);
    step(0, 0, 3);
    // reset mid-press
    step(1, 0, 14);
    step(1, 1, 1);
    step(1, 0, 10);
    step(0, 0, 3);
    step(1, 0, 3);
    step(0, 0, GC);
    push(EV_CLICK);
    step(0, 0, 3);
    // reset inside the click gap drops the pending click
    step(1, 0, 3);
    step(0, 0, 3);
    step(0, 1, 1);
    step(0, 0, 12);
    step(0, 0, 3);
    checks++;
    assert (sbq.size() == 0) else begin
      errors++;
      $error("FAIL queue_drain got=%0d exp=0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
